pll_reset_ctrl: RTL
===================

Name: pll_reset_ctrl

Overview:
- Fabric-side responder to the board PLL's control/status pair. Consumes the PLL `LOCKED` status and drives the PLL `RST` and `PWRDWN` inputs back.
- Sequences PLL reset pulses, lock-wait with timeout and retry, and a lock-stability hold-off.
- Releases a synchronous system reset to downstream logic (counters, display) only after lock is proven stable.
- Sits in the board wrapper between the PLL primitive and all clocked user logic; exposes status for LEDs.

Parameters:
- RST_PULSE_CYCLES, 16: cycles `pll_rst` is held high per reset attempt (≥1).
- LOCK_TIMEOUT, 4096: cycles to wait for lock after `pll_rst` falls before retrying (≥1).
- STABLE_CYCLES, 1024: consecutive synchronized-locked cycles required before reset release (≥1).
- MAX_RETRY, 3: reset attempts allowed before declaring fault (≥1).
- CNT_W, 8: width of the lock-loss event counter.
- SYNC_STAGES, 2: flops in the `pll_locked` synchronizer (≥2).

Ports:
- clk  in  1  free-running reference clock, not the PLL output.
- rst  in  1  synchronous, active-high reset.
- pll_locked  in  1  PLL `LOCKED`; asynchronous to clk.
- pwrdn_req  in  1  level request to power the PLL down.
- clr_fault  in  1  single-cycle pulse that leaves FAULT.
- pll_rst  out  1  to PLL `RST`.
- pll_pwrdwn  out  1  to PLL `PWRDWN`.
- sys_rst  out  1  active-high synchronous reset for user logic.
- sys_rst_n  out  1  always equal to ~sys_rst.
- ready  out  1  high only in RUN.
- fault  out  1  high only in FAULT.
- lock_loss_cnt  out  CNT_W  saturating count of lock losses seen while in RUN.
- state_o  out  3  current state encoding, for debug.

Behaviour:
- Synchronizer:
  - `pll_locked` passes through SYNC_STAGES flops to give `locked_s`.
  - All decisions use `locked_s` only.
  - The synchronizer is cleared to 0 by rst.
- State machine:
  - States: PWRDN, PLL_RST, WAIT_LOCK, STABLE, RUN, FAULT.
  - One shared timer, cleared on every state change.
  - One retry counter.
- Reset (rst=1) results:
  - state=PLL_RST, timer=0, retry=0, lock_loss_cnt=0.
  - Outputs: pll_rst=1, pll_pwrdwn=0, sys_rst=1, sys_rst_n=0, ready=0, fault=0.
- Output timing:
  - All outputs are registered and Moore-decoded from the next state, so they change on the same edge as state.
- Priority order: rst > pwrdn_req > clr_fault > normal transitions.
- PWRDN:
  - Entered from any state while pwrdn_req=1.
  - Outputs: pll_pwrdwn=1, pll_rst=1, sys_rst=1.
  - When pwrdn_req=0, go to PLL_RST with retry=0.
- PLL_RST:
  - Output: pll_rst=1.
  - Timer counts 0..RST_PULSE_CYCLES-1; on the last count go to WAIT_LOCK. The pulse is exactly RST_PULSE_CYCLES cycles.
- WAIT_LOCK:
  - Output: pll_rst=0.
  - If locked_s=1, go to STABLE.
  - Else on timer==LOCK_TIMEOUT-1:
    - if retry==MAX_RETRY-1, go to FAULT;
    - otherwise retry++ and go to PLL_RST.
- STABLE:
  - If locked_s=0, go to WAIT_LOCK. This is a glitch; retry is not incremented.
  - Else on timer==STABLE_CYCLES-1, go to RUN and clear retry.
- RUN:
  - Outputs: sys_rst=0, ready=1.
  - If locked_s=0:
    - go to PLL_RST;
    - lock_loss_cnt++, saturating at 2^CNT_W-1.
- FAULT:
  - Outputs: pll_rst=1, sys_rst=1, fault=1.
  - Held until rst, or clr_fault=1, which goes to PLL_RST with retry=0.
  - clr_fault is ignored in all other states.
- Latency:
  - If pll_locked rises and stays high at edge t while in WAIT_LOCK, RUN is entered at edge t+SYNC_STAGES+STABLE_CYCLES+1.
  - If lock falls in RUN, sys_rst asserts within SYNC_STAGES+1 edges.
- Simultaneous events:
  - locked_s=1 on the same edge as WAIT_LOCK timeout goes to STABLE; lock wins.
  - pwrdn_req during FAULT goes to PWRDN; release then returns to PLL_RST and clears the fault.
- Timer width: $clog2 of the maximum of the three cycle parameters, plus 1.

Decomposition:
- Package `pll_reset_pkg`:
  - `typedef enum logic [2:0]` for state: PWRDN=0, PLL_RST=1, WAIT_LOCK=2, STABLE=3, RUN=4, FAULT=5. state_o carries this encoding.
  - Function computing the timer width.
- Sub-module `sync_bit`:
  - Parameterized SYNC_STAGES flop chain, synchronous reset to 0.
  - Reused for switch inputs elsewhere in the design.

Test Plan:
- Bench parameters: RST_PULSE_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=3, SYNC_STAGES=2, CNT_W=2.
- Normal lock: after rst release, pll_rst is high 4 cycles. Drive pll_locked=1 at edge t (10 cycles after pll_rst falls) -> ready=1 and sys_rst=0 at t+11; lock_loss_cnt=0.
- Never lock: pll_locked=0 -> three 4-cycle pll_rst pulses 24 cycles apart, then fault=1 at edge 72 after rst release. sys_rst stays 1 throughout.
- Glitch: drop pll_locked for 3 cycles mid-STABLE -> state returns to WAIT_LOCK, then STABLE. ready is delayed by a full restart of the 8-cycle count; retry and lock_loss_cnt unchanged.
- Lock loss in RUN: drop pll_locked -> sys_rst=1 within 3 cycles, then a 4-cycle pll_rst pulse, lock_loss_cnt=1. Repeat 4 more losses -> lock_loss_cnt saturates at 3.
- pwrdn_req=1 in RUN -> next edge pll_pwrdwn=1, pll_rst=1, sys_rst=1. Deassert -> PLL_RST for 4 cycles, then WAIT_LOCK.
- clr_fault pulse in FAULT -> PLL_RST with retry=0, fault=0. Assert rst mid-WAIT_LOCK -> PLL_RST with all counters cleared and pll_rst=1 on the next edge.

Source files
------------

// File: rtl/pll_reset_pkg.sv
// Shared definitions for the PLL reset controller.
//   pll_state_e  : controller state encoding, also driven out on state_o
//   timer_width(): width of the shared phase timer for a given set of
//                  cycle-count parameters
package pll_reset_pkg;

    typedef enum logic [2:0] {
        PWRDN     = 3'd0,
        PLL_RST   = 3'd1,
        WAIT_LOCK = 3'd2,
        STABLE    = 3'd3,
        RUN       = 3'd4,
        FAULT     = 3'd5
    } pll_state_e;

    // One bit of headroom over the largest terminal count.
    function automatic int timer_width(input int rst_pulse,
                                       input int lock_timeout,
                                       input int stable_cycles);
        int m;
        m = rst_pulse;
        if (lock_timeout > m) m = lock_timeout;
        if (stable_cycles > m) m = stable_cycles;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/pll_reset_sync_bit.sv
// Single-bit synchronizer: SYNC_STAGES flops in a chain, cleared to 0 by a
// synchronous active-high reset. Generic, also used for switch inputs.
//   clk : destination clock
//   rst : synchronous active-high reset
//   d   : asynchronous input
//   q   : synchronized output
module sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset / lock sequencer. Pulses the PLL reset, waits for lock with
// timeout and bounded retries, requires lock to stay up for a hold-off
// period, then releases the system reset for downstream logic.
//   clk           : free-running reference clock (not the PLL output)
//   rst           : synchronous active-high reset
//   pll_locked    : PLL LOCKED status, asynchronous to clk
//   pwrdn_req     : level request to power the PLL down
//   clr_fault     : single-cycle pulse, leaves FAULT
//   pll_rst       : to PLL RST
//   pll_pwrdwn    : to PLL PWRDWN
//   sys_rst       : active-high synchronous reset for user logic
//   sys_rst_n     : complement of sys_rst
//   ready         : high only in RUN
//   fault         : high only in FAULT
//   lock_loss_cnt : saturating count of lock losses while in RUN
//   state_o       : current state encoding
//
// state     | meaning
// ----------+-----------------------------------------------------------
// PWRDN     | PLL held powered down and in reset
// PLL_RST   | PLL reset pulse, RST_PULSE_CYCLES long
// WAIT_LOCK | reset released, waiting for lock (timeout -> retry/fault)
// STABLE    | locked, counting STABLE_CYCLES before releasing sys_rst
// RUN       | lock proven, sys_rst released
// FAULT     | retries exhausted, waits for clr_fault or rst
module pll_reset_ctrl
    import pll_reset_pkg::*;
#(
    parameter int RST_PULSE_CYCLES = 16,
    parameter int LOCK_TIMEOUT     = 4096,
    parameter int STABLE_CYCLES    = 1024,
    parameter int MAX_RETRY        = 3,
    parameter int CNT_W            = 8,
    parameter int SYNC_STAGES      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             pwrdn_req,
    input  logic             clr_fault,
    output logic             pll_rst,
    output logic             pll_pwrdwn,
    output logic             sys_rst,
    output logic             sys_rst_n,
    output logic             ready,
    output logic             fault,
    output logic [CNT_W-1:0] lock_loss_cnt,
    output logic [2:0]       state_o
);

    localparam int TMR_W = timer_width(RST_PULSE_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int RTY_W = $clog2(MAX_RETRY) + 1;

    localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(RST_PULSE_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCK_LAST   = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] STABLE_LAST = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [RTY_W-1:0] RETRY_LAST  = RTY_W'(MAX_RETRY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    pll_state_e       state, state_n;
    logic [TMR_W-1:0] timer, timer_n;
    logic [RTY_W-1:0] retry, retry_n;
    logic [CNT_W-1:0] loss_n;
    logic             locked_s;
    logic             pll_rst_d, pll_pwrdwn_d, sys_rst_d, ready_d, fault_d;

    sync_bit #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    always_comb begin
        state_n = state;
        retry_n = retry;
        loss_n  = lock_loss_cnt;

        if (pwrdn_req) begin
            state_n = PWRDN;
        end else begin
            case (state)
                PWRDN: begin
                    state_n = PLL_RST;
                    retry_n = '0;
                end
                PLL_RST: begin
                    if (timer == RST_LAST) state_n = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    // Lock wins over a timeout on the same cycle.
                    if (locked_s) begin
                        state_n = STABLE;
                    end else if (timer == LOCK_LAST) begin
                        if (retry == RETRY_LAST) begin
                            state_n = FAULT;
                        end else begin
                            state_n = PLL_RST;
                            retry_n = retry + RTY_W'(1);
                        end
                    end
                end
                STABLE: begin
                    // A dropout here is treated as a glitch, not a failed attempt.
                    if (!locked_s) begin
                        state_n = WAIT_LOCK;
                    end else if (timer == STABLE_LAST) begin
                        state_n = RUN;
                        retry_n = '0;
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state_n = PLL_RST;
                        if (lock_loss_cnt != CNT_MAX) loss_n = lock_loss_cnt + CNT_W'(1);
                    end
                end
                FAULT: begin
                    if (clr_fault) begin
                        state_n = PLL_RST;
                        retry_n = '0;
                    end
                end
                default: begin
                    state_n = PLL_RST;
                    retry_n = '0;
                end
            endcase
        end
    end

    // Timer restarts on every state change and only runs in the timed phases.
    always_comb begin
        timer_n = timer;
        if (state_n != state) begin
            timer_n = '0;
        end else if (state == PLL_RST || state == WAIT_LOCK || state == STABLE) begin
            timer_n = timer + TMR_W'(1);
        end
    end

    // Outputs decoded from the next state so they move on the same edge as state.
    always_comb begin
        pll_rst_d    = 1'b0;
        pll_pwrdwn_d = 1'b0;
        sys_rst_d    = 1'b1;
        ready_d      = 1'b0;
        fault_d      = 1'b0;
        case (state_n)
            PWRDN: begin
                pll_pwrdwn_d = 1'b1;
                pll_rst_d    = 1'b1;
            end
            PLL_RST:   pll_rst_d = 1'b1;
            WAIT_LOCK: pll_rst_d = 1'b0;
            STABLE:    pll_rst_d = 1'b0;
            RUN: begin
                sys_rst_d = 1'b0;
                ready_d   = 1'b1;
            end
            FAULT: begin
                pll_rst_d = 1'b1;
                fault_d   = 1'b1;
            end
            default:   pll_rst_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= PLL_RST;
            timer         <= '0;
            retry         <= '0;
            lock_loss_cnt <= '0;
            pll_rst       <= 1'b1;
            pll_pwrdwn    <= 1'b0;
            sys_rst       <= 1'b1;
            sys_rst_n     <= 1'b0;
            ready         <= 1'b0;
            fault         <= 1'b0;
        end else begin
            state         <= state_n;
            timer         <= timer_n;
            retry         <= retry_n;
            lock_loss_cnt <= loss_n;
            pll_rst       <= pll_rst_d;
            pll_pwrdwn    <= pll_pwrdwn_d;
            sys_rst       <= sys_rst_d;
            sys_rst_n     <= ~sys_rst_d;
            ready         <= ready_d;
            fault         <= fault_d;
        end
    end

    assign state_o = state;

endmodule
